// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-master arbiter and access sequencer for the single-ported data memory.
// Master 0 is the CPU load/store port, master 1 a secondary requester (DMA or
// debug). One word transaction is granted at a time with round-robin priority
// on ties. Each legal access holds the memory for WAIT+1 cycles. Misaligned or
// out-of-range addresses never reach the memory. Instead they complete one
// cycle after the grant with the err flag set.
//
// State table:
//   S_IDLE   | no transaction; arbitrate and address-check on the next edge
//   S_ACCESS | memory driven from latched regs; cnt counts down wait states
//   S_RESP   | ready/err/rdata pulse visible to the granted master
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   m0_* / m1_*           per-master request (req, we, addr, wdata) and
//                         response (ready, err, rdata) channels
//   mem_addr/wdata/we     DM access, word address with [1:0] forced to 00
//   mem_rdata             DM combinational read data
//   busy                  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int unsigned WAIT     = 1,
  parameter logic [31:0] DM_START = 32'h0000_0000,
  parameter logic [31:0] DM_END   = 32'h0000_2ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
  // Range check as a single unsigned compare: addr lies in [START, END]
  // exactly when (addr - START) mod 2^32 <= END - START.
  localparam logic [31:0] DM_SPAN  = DM_END - DM_START;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic        r_we;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic        r_m0_ready;
  logic        r_m0_err;
  logic [31:0] r_m0_rdata;
  logic        r_m1_ready;
  logic        r_m1_err;
  logic [31:0] r_m1_rdata;

  logic        w_any_req;
  logic        w_grant;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_addr_err;
  logic        w_final;

  assign w_any_req   = m0_req | m1_req;
  // On a tie the master that was not granted last wins.
  assign w_grant     = (m0_req && m1_req) ? ~r_last : m1_req;
  assign w_sel_we    = w_grant ? m1_we    : m0_we;
  assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;
  assign w_addr_err  = (w_sel_addr[1:0] != 2'b00) ||
                       ((w_sel_addr - DM_START) > DM_SPAN);
  assign w_final     = (r_state == S_ACCESS) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_cnt      <= 4'd0;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_ready <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ready <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      r_m0_ready <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ready <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr[31:2];
            r_wdata <= w_sel_wdata;
            if (w_addr_err) begin
              // Bad address: skip the memory and respond next cycle.
              r_state <= S_RESP;
              if (w_grant) begin
                r_m1_ready <= 1'b1;
                r_m1_err   <= 1'b1;
              end else begin
                r_m0_ready <= 1'b1;
                r_m0_err   <= 1'b1;
              end
            end else begin
              r_cnt   <= WAIT_CNT;
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Final access edge: write commits via mem_we, reads are captured.
            r_state <= S_RESP;
            if (r_id) begin
              r_m1_ready <= 1'b1;
              r_m1_rdata <= r_we ? 32'd0 : mem_rdata;
            end else begin
              r_m0_ready <= 1'b1;
              r_m0_rdata <= r_we ? 32'd0 : mem_rdata;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m0_ready  = r_m0_ready;
  assign m0_err    = r_m0_err;
  assign m0_rdata  = r_m0_rdata;
  assign m1_ready  = r_m1_ready;
  assign m1_err    = r_m1_err;
  assign m1_rdata  = r_m1_rdata;
  assign mem_addr  = {r_addr, 2'b00};
  assign mem_wdata = r_wdata;
  // Gated by reset so an aborted write never reaches the memory.
  assign mem_we    = w_final && r_we && !reset;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Main instance (WAIT=1) runs against a transaction-level reference model. The
// model schedules, per grant, the cycle of the ready pulse, the busy window and
// the write-commit cycle. A word-array memory image yields the expected read
// data. Two extra instances (WAIT=0, WAIT=4) check the wait-state timing and
// back-to-back requests from a held req.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int          W      = 1;
  localparam logic [31:0] DM_END = 32'h0000_2ffc;
  localparam int          N      = 2048;
  localparam logic [31:0] X_RD   = 32'h5a5a_0f0f;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit [31:0] dm [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_we) dm[mem_addr[13:2]] <= mem_wdata;
  assign mem_rdata = dm[mem_addr[13:2]];

  dm_arbiter #(.WAIT(W)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Wait-state sweep instances: m0 reads a fixed word, m1 stays idle.
  logic        x_req;
  logic        z1;
  logic [31:0] z32, x_addr, x_rd;
  logic        a_rdy0, a_err0, a_rdy1, a_err1, a_we, a_busy;
  logic [31:0] a_rd0, a_rd1, a_maddr, a_mwd;
  logic        b_rdy0, b_err0, b_rdy1, b_err1, b_we, b_busy;
  logic [31:0] b_rd0, b_rd1, b_maddr, b_mwd;

  assign z1     = 1'b0;
  assign z32    = 32'd0;
  assign x_addr = 32'h0000_0040;
  assign x_rd   = X_RD;

  dm_arbiter #(.WAIT(0)) u_w0 (
    .clk(clk), .reset(reset),
    .m0_req(x_req), .m0_we(z1), .m0_addr(x_addr), .m0_wdata(z32),
    .m0_ready(a_rdy0), .m0_err(a_err0), .m0_rdata(a_rd0),
    .m1_req(z1), .m1_we(z1), .m1_addr(z32), .m1_wdata(z32),
    .m1_ready(a_rdy1), .m1_err(a_err1), .m1_rdata(a_rd1),
    .mem_addr(a_maddr), .mem_wdata(a_mwd), .mem_we(a_we),
    .mem_rdata(x_rd), .busy(a_busy)
  );

  dm_arbiter #(.WAIT(4)) u_w4 (
    .clk(clk), .reset(reset),
    .m0_req(x_req), .m0_we(z1), .m0_addr(x_addr), .m0_wdata(z32),
    .m0_ready(b_rdy0), .m0_err(b_err0), .m0_rdata(b_rd0),
    .m1_req(z1), .m1_we(z1), .m1_addr(z32), .m1_wdata(z32),
    .m1_ready(b_rdy1), .m1_err(b_err1), .m1_rdata(b_rd1),
    .mem_addr(b_maddr), .mem_wdata(b_mwd), .mem_we(b_we),
    .mem_rdata(x_rd), .busy(b_busy)
  );

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (main instance).
  // ---------------------------------------------------------------------------
  bit        e_rdy0 [N];
  bit        e_rdy1 [N];
  bit        e_err0 [N];
  bit        e_err1 [N];
  bit [31:0] e_rd0  [N];
  bit [31:0] e_rd1  [N];
  bit        e_busy [N];
  bit        e_we   [N];
  bit [31:0] e_wa   [N];
  bit [31:0] e_wd   [N];
  bit [31:0] mmem   [0:4095];

  int          free_c  = 0;
  bit          last_g  = 1'b1;
  bit          pend    = 1'b0;
  int          p_commit, p_rdy, mt, lat;
  bit          p_m, p_we, g, e;
  logic [31:0] p_addr, p_wd, a;

  always @(negedge clk) begin
    mt = cyc;
    if (mt >= 1 && mt < N) begin
      chk1($sformatf("m0_ready@%0d", mt), m0_ready, e_rdy0[mt]);
      chk1($sformatf("m1_ready@%0d", mt), m1_ready, e_rdy1[mt]);
      chk1($sformatf("m0_err@%0d", mt), m0_err, e_err0[mt]);
      chk1($sformatf("m1_err@%0d", mt), m1_err, e_err1[mt]);
      chk32($sformatf("m0_rdata@%0d", mt), m0_rdata, e_rd0[mt]);
      chk32($sformatf("m1_rdata@%0d", mt), m1_rdata, e_rd1[mt]);
      chk1($sformatf("busy@%0d", mt), busy, e_busy[mt]);
      chk1($sformatf("mem_we@%0d", mt), mem_we, e_we[mt] && !reset);
      if (e_we[mt] && !reset) begin
        chk32($sformatf("mem_addr@%0d", mt), mem_addr, e_wa[mt]);
        chk32($sformatf("mem_wdata@%0d", mt), mem_wdata, e_wd[mt]);
      end
    end
    if (mt < N - 40) begin
      if (reset) begin
        // Abort: nothing scheduled after this cycle happens.
        for (int k = mt + 1; k < mt + 32; k++) begin
          e_rdy0[k] = 0; e_rdy1[k] = 0; e_err0[k] = 0; e_err1[k] = 0;
          e_rd0[k] = 0; e_rd1[k] = 0; e_busy[k] = 0; e_we[k] = 0;
        end
        pend   = 0;
        last_g = 1'b1;
        free_c = mt + 1;
      end else begin
        if (pend && mt == p_commit) begin
          if (p_we) mmem[p_addr[13:2]] = p_wd;
          else if (p_m) e_rd1[p_rdy] = mmem[p_addr[13:2]];
          else e_rd0[p_rdy] = mmem[p_addr[13:2]];
        end
        if (pend && mt == p_rdy) pend = 0;
        if (mt >= free_c && (m0_req || m1_req)) begin
          g = (m0_req && m1_req) ? ~last_g : m1_req;
          a = g ? m1_addr : m0_addr;
          // Lower bound is address 0, so only the upper bound can be exceeded.
          e = (a[1:0] != 2'b00) || (a > DM_END);
          lat = e ? 1 : W + 2;
          if (g) begin e_rdy1[mt + lat] = 1; e_err1[mt + lat] = e; end
          else begin e_rdy0[mt + lat] = 1; e_err0[mt + lat] = e; end
          for (int k = mt + 1; k <= mt + lat; k++) e_busy[k] = 1;
          if (!e) begin
            pend     = 1;
            p_m      = g;
            p_we     = g ? m1_we : m0_we;
            p_addr   = a;
            p_wd     = g ? m1_wdata : m0_wdata;
            p_commit = mt + W + 1;
            p_rdy    = mt + lat;
            if (p_we) begin
              e_we[p_commit] = 1;
              e_wa[p_commit] = a;
              e_wd[p_commit] = p_wd;
            end
          end
          free_c = mt + lat + 1;
          last_g = g;
        end
      end
    end
  end

  int we_cnt = 0;
  int we_cyc = -1;
  always @(negedge clk) if (mem_we) begin we_cnt++; we_cyc = cyc; end

  // One transaction for master m; called just after a rising edge. Returns the
  // cycle req was first presented and the cycle ready was seen.
  task automatic txn(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, output int ts, output int tr,
                     output logic [31:0] rd, output logic er);
    bit got = 0;
    ts = cyc; tr = -1; rd = '0; er = 1'b0;
    if (m == 0) begin m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1; end
    else begin m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (m == 0 ? m0_ready : m1_ready) begin
        got = 1;
        tr  = cyc;
        rd  = (m == 0) ? m0_rdata : m1_rdata;
        er  = (m == 0) ? m0_err : m1_err;
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout m%0d addr=%h actual=no_ready required=ready", m, addr);
    end
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  int          ts0, tr0, ts1, tr1, w0, s;
  logic [31:0] rd0, rd1;
  logic        er0, er1;
  int          n_a, n_b, ca1, ca2, cb1, cb2;
  logic [31:0] rda, rdb;
  logic        era;

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    x_req = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;

    // Write then read back, WAIT=1.
    w0 = we_cnt;
    txn(0, 1'b1, 32'h10, 32'h1234_5678, ts0, tr0, rd0, er0);
    chki("wr_latency", tr0 - ts0, 3);
    chk1("wr_err", er0, 1'b0);
    chki("wr_we_count", we_cnt - w0, 1);
    chki("wr_we_cycle", we_cyc - ts0, 2);
    txn(0, 1'b0, 32'h10, 32'h0, ts0, tr0, rd0, er0);
    chk32("rd_data", rd0, 32'h1234_5678);
    chki("rd_latency", tr0 - ts0, 3);

    // Tie right after reset: m0 first, m1 one slot later.
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    fork
      txn(0, 1'b0, 32'h10, 32'h0, ts0, tr0, rd0, er0);
      txn(1, 1'b0, 32'h0, 32'h0, ts1, tr1, rd1, er1);
    join
    chki("tie1_m0_latency", tr0 - ts0, 3);
    chki("tie1_m1_after_m0", tr1 - tr0, W + 3);
    chk32("tie1_m0_rdata", rd0, 32'h1234_5678);

    // m0 alone at address 0 (lower boundary), then a tie: m1 must win.
    txn(0, 1'b0, 32'h0, 32'h0, ts0, tr0, rd0, er0);
    chk1("addr0_err", er0, 1'b0);
    fork
      txn(0, 1'b0, 32'h10, 32'h0, ts0, tr0, rd0, er0);
      txn(1, 1'b0, 32'h10, 32'h0, ts1, tr1, rd1, er1);
    join
    chki("tie2_m0_after_m1", tr0 - tr1, W + 3);
    chk32("tie2_m1_rdata", rd1, 32'h1234_5678);

    // Address errors.
    w0 = we_cnt;
    txn(1, 1'b0, 32'h13, 32'h0, ts1, tr1, rd1, er1);
    chk1("misalign_err", er1, 1'b1);
    chki("misalign_latency", tr1 - ts1, 1);
    chk32("misalign_rdata", rd1, 32'd0);
    txn(0, 1'b1, 32'h3000, 32'hffff_ffff, ts0, tr0, rd0, er0);
    chk1("oor_err", er0, 1'b1);
    chki("oor_latency", tr0 - ts0, 1);
    chki("err_no_write", we_cnt - w0, 0);

    // Upper boundary word.
    txn(1, 1'b1, 32'h2ffc, 32'hcafe_f00d, ts1, tr1, rd1, er1);
    chk1("top_wr_err", er1, 1'b0);
    txn(0, 1'b0, 32'h2ffc, 32'h0, ts0, tr0, rd0, er0);
    chk32("top_rd_data", rd0, 32'hcafe_f00d);

    // Reset during the final ACCESS cycle of a write to 0x20.
    w0 = we_cnt;
    m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hdead_beef; m0_req = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    chki("abort_cycle", cyc - s, 2);
    chk1("abort_mem_we", mem_we, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", m0_ready, 1'b0);
    chki("abort_no_write", we_cnt - w0, 0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, ts0, tr0, rd0, er0);
    chk32("abort_rd_20", rd0, 32'd0);

    // WAIT sweep with req held across ready: two back-to-back transactions.
    n_a = 0; n_b = 0; ca1 = -100; ca2 = -100; cb1 = -100; cb2 = -100;
    rda = '0; rdb = '0; era = 1'b1;
    x_req = 1'b1;
    s = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_rdy0) begin
        if (n_a == 0) begin ca1 = cyc; rda = a_rd0; era = a_err0; end
        else if (n_a == 1) ca2 = cyc;
        n_a++;
      end
      if (b_rdy0) begin
        if (n_b == 0) begin cb1 = cyc; rdb = b_rd0; end
        else if (n_b == 1) cb2 = cyc;
        n_b++;
      end
    end
    @(posedge clk); #1 x_req = 1'b0;
    chki("w0_first_ready", ca1 - s, 2);
    chki("w0_second_ready", ca2 - s, 5);
    chk32("w0_rdata", rda, X_RD);
    chk1("w0_err", era, 1'b0);
    chki("w4_first_ready", cb1 - s, 6);
    chki("w4_second_ready", cb2 - s, 13);
    chk32("w4_rdata", rdb, X_RD);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter and access sequencer for the single-ported data memory (DM). It sits between the CPU load/store port (master 0) and a second requester such as a DMA or debug port (master 1). It grants one word transaction at a time under round-robin priority and inserts a configurable number of memory wait states. It performs the word-alignment and DM-range check before touching memory, and returns a per-master done pulse with read data or an error flag; the error flag is mapped to AdEL/AdES upstream.

## Interface
Parameters:
- WAIT, 1: extra wait cycles per memory access (0..15).
- DM_START, 32'h0000_0000: lowest legal byte address.
- DM_END, 32'h0000_2ffc: highest legal word address.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- m0_req / m1_req  in  1  request; held high until that master's ready pulse.
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high.
- m0_addr / m1_addr  in  32  byte address; stable while req high.
- m0_wdata / m1_wdata  in  32  write data; stable while req high.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  valid with ready; address misaligned or out of range.
- m0_rdata / m1_rdata  out  32  read data, valid with ready for reads; 0 for writes and errors.
- mem_addr  out  32  DM word address, with bits [1:0] forced to 00.
- mem_wdata  out  32  DM write data.
- mem_we  out  1  DM write strobe (DM writes on the clock edge).
- mem_rdata  in  32  DM combinational read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that master.
  - If both are high, grant the master not granted last. The last-grant register resets to 1, so m0 wins the first tie.
  - On grant, latch id, we, addr, wdata and update last-grant.
- **Address check**, in IDLE on the requesting master's addr:
  - error if addr[1:0] != 00, addr < DM_START, or addr > DM_END.
  - On error: latch err = 1 and go directly to RESP; the memory is never accessed.
  - Otherwise: err = 0, load cnt = WAIT, go to ACCESS.
- **ACCESS:**
  - mem_addr and mem_wdata are driven from the latched registers.
  - If cnt != 0: decrement cnt and stay in ACCESS.
  - If cnt == 0: mem_we = latched we, which commits the write on this edge. For a read, capture mem_rdata into the rdata register on this edge. Go to RESP.
- **RESP:**
  - Pulse ready, err and rdata to the granted master only. The other master sees ready = 0, err = 0, rdata = 0.
  - Go to IDLE.
- **Protocol:**
  - A master drops req in the cycle after it sees ready. If req is still high in the following IDLE, it is a new transaction.
  - If req drops mid-transaction, the transaction still completes, including the write, and ready still pulses. This is a protocol violation and is not flagged.
- mem_we is high only in the final ACCESS cycle of a legal write and is gated by !reset.

## Timing
- Reset values: state = IDLE, last-grant = 1, cnt = 0; all latched registers 0; mem_addr = 0, mem_wdata = 0, mem_we = 0; all ready, err and rdata = 0; busy = 0.
- Reset asserted in any state returns the block to IDLE on that edge. An in-flight write is not committed: mem_we is low while reset is high. No ready pulse is emitted for the aborted transaction.
- Cycle numbering: request sampled in IDLE at cycle 0. Then:
  - legal access: ACCESS spans cycles 1..WAIT+1, ready is high in cycle WAIT+2.
  - error: ready is high in cycle 1.
- Throughput: one legal transaction per WAIT+3 cycles (IDLE + ACCESS + RESP). A pending request from the other master is granted in the IDLE cycle right after RESP.
- rdata reflects the DM contents at the final ACCESS edge. A write issued by the other master afterwards does not affect it.
- A read of an address written in the immediately preceding transaction returns the new data.

## Test plan
- Reset, then m0 write 0x1234_5678 to 0x0000_0010 with WAIT = 1 -> mem_we high for exactly one cycle (cycle 2); m0_ready in cycle 3 with err = 0. A following m0 read of 0x10 -> rdata = 0x1234_5678.
- m0 and m1 both request reads in the same cycle, both holding req -> m0 is granted first and m1 next, with m1_ready exactly WAIT+3 cycles after m0_ready. On a repeated tie, m1 is granted first (alternation).
- m1 reads 0x0000_0013 (misaligned) -> m1_err = 1 and m1_ready in cycle 1, rdata = 0, mem_we never asserted. m0 write to 0x0000_3000 (out of range) -> m0_err = 1, no write.
- Boundary addresses 0x0000_2ffc and 0x0000_0000 -> legal; 0x0000_3000 -> err.
- Reset pulsed during the final ACCESS cycle of a write to 0x20 -> no write (a later read of 0x20 returns 0), no ready, busy = 0 the next cycle.
- Sweep WAIT = 0 and WAIT = 4 -> ready in cycle 2 and cycle 6 respectively. m0 holds req after its ready pulse -> treated as a second transaction.
